// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
//
// This block is a two-master, one-slave arbiter for the dcpu memory bus, which
// uses an addr/dat/we/cs/ack protocol. Master 0 is the CPU core. Master 1 is the
// DMA/debug loader.
//
// Arbitration:
//   - Round-robin.
//   - The grant is held for one whole transaction.
//   - There is one IDLE bubble cycle between transactions.
//
// Watchdog: if the slave does not ack within 2^TIMEOUT_W-1 busy cycles, the
// arbiter completes the transaction itself. It returns ERR_DATA and pulses o_err.
//
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_mN_addr/dat/we/cs        master N request (N = 0, 1)
//   o_mN_dat, o_mN_ack         read data / ack back to master N
//   o_s_addr/dat/we/cs         request forwarded to the slave
//   i_s_dat, i_s_ack           slave response
//   o_err                      one-cycle pulse when the watchdog fires
//   o_grant                    one-hot current grant, 00 when idle (debug)
// -----------------------------------------------------------------------------
module dbus_arbiter #(
    parameter int          TIMEOUT_W = 8,
    parameter logic [15:0] ERR_DATA  = 16'hDEAD
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    input  logic        i_m0_we,
    input  logic        i_m0_cs,
    output logic [15:0] o_m0_dat,
    output logic        o_m0_ack,

    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    input  logic        i_m1_we,
    input  logic        i_m1_cs,
    output logic [15:0] o_m1_dat,
    output logic        o_m1_ack,

    output logic [15:0] o_s_addr,
    output logic [15:0] o_s_dat,
    output logic        o_s_we,
    output logic        o_s_cs,
    input  logic [15:0] i_s_dat,
    input  logic        i_s_ack,

    output logic        o_err,
    output logic [1:0]  o_grant
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   gnt_q, gnt_d;     // index of the granted master
    logic                   last_q, last_d;   // index of the last master served
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;     // busy cycles without ack

    logic        busy;
    logic        g_cs;
    logic        g_we;
    logic [15:0] g_addr;
    logic [15:0] g_dat;
    logic        wd_expired;
    logic        timeout;
    logic        done;
    logic [15:0] g_rdat;

    // Signals of the currently granted master.
    assign busy   = (state_q == BUSY);
    assign g_cs   = gnt_q ? i_m1_cs   : i_m0_cs;
    assign g_we   = gnt_q ? i_m1_we   : i_m0_we;
    assign g_addr = gnt_q ? i_m1_addr : i_m0_addr;
    assign g_dat  = gnt_q ? i_m1_dat  : i_m0_dat;

    // A real slave ack in the expiry cycle wins over the watchdog.
    assign wd_expired = (cnt_q == {TIMEOUT_W{1'b1}});
    assign timeout    = busy & g_cs & wd_expired & ~i_s_ack;
    assign done       = busy & g_cs & (i_s_ack | wd_expired);
    assign g_rdat     = timeout ? ERR_DATA : i_s_dat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cs || i_m1_cs) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    // On a tie, serve whichever master was not served last.
                    gnt_d   = (i_m0_cs && i_m1_cs) ? ~last_q : i_m1_cs;
                end
            end
            BUSY: begin
                if (!g_cs) begin
                    // The master withdrew its request: abandon it silently.
                    state_d = IDLE;
                end else if (done) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The slave sees a request only while it is owned and has not timed out.
    always_comb begin
        o_s_cs   = busy & g_cs & ~timeout;
        o_s_we   = o_s_cs & g_we;
        o_s_addr = busy ? g_addr : 16'h0000;
        o_s_dat  = busy ? g_dat  : 16'h0000;

        o_m0_ack = done & ~gnt_q;
        o_m1_ack = done &  gnt_q;
        o_m0_dat = (busy && !gnt_q) ? g_rdat : 16'h0000;
        o_m1_dat = (busy &&  gnt_q) ? g_rdat : 16'h0000;

        o_err    = timeout;
        o_grant  = busy ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

    localparam int          TW  = 3;
    localparam logic [15:0] ERR = 16'hDEAD;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a0, d0, a1, d1, sdat;
    logic        we0, c0, we1, c1, sack;

    logic [15:0] s_addr, s_dat_o, m0_dat, m1_dat;
    logic        s_we, s_cs, m0_ack, m1_ack, err;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    dbus_arbiter #(.TIMEOUT_W(TW), .ERR_DATA(ERR)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_addr(a0), .i_m0_dat(d0), .i_m0_we(we0), .i_m0_cs(c0),
        .o_m0_dat(m0_dat), .o_m0_ack(m0_ack),
        .i_m1_addr(a1), .i_m1_dat(d1), .i_m1_we(we1), .i_m1_cs(c1),
        .o_m1_dat(m1_dat), .o_m1_ack(m1_ack),
        .o_s_addr(s_addr), .o_s_dat(s_dat_o), .o_s_we(s_we), .o_s_cs(s_cs),
        .i_s_dat(sdat), .i_s_ack(sack),
        .o_err(err), .o_grant(grant)
    );

    typedef struct {
        logic        rst, c0, we0;
        logic [15:0] a0, d0;
        logic        c1, we1;
        logic [15:0] a1, d1;
        logic        sack;
        logic [15:0] sd;
        logic        scs, swe;
        logic [15:0] saddr, sdo;
        logic [1:0]  gnt;
        logic        ack0, ack1;
        logic [15:0] r0, r1;
        logic        err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic e_scs, input logic [1:0] e_gnt,
                           input logic e_ack0, input logic e_ack1, input logic e_err);
        chk({tag, ".s_cs"}, 16'(s_cs), 16'(e_scs));
        chk({tag, ".grant"}, 16'(grant), 16'(e_gnt));
        chk({tag, ".m0_ack"}, 16'(m0_ack), 16'(e_ack0));
        chk({tag, ".m1_ack"}, 16'(m1_ack), 16'(e_ack1));
        chk({tag, ".err"}, 16'(err), 16'(e_err));
    endtask

    task automatic run_vec(input vec_t v, input int i);
        rst = v.rst; c0 = v.c0; we0 = v.we0; a0 = v.a0; d0 = v.d0;
        c1 = v.c1; we1 = v.we1; a1 = v.a1; d1 = v.d1; sack = v.sack; sdat = v.sd;
        #3;
        chk($sformatf("v%0d.s_we", i), 16'(s_we), 16'(v.swe));
        chk($sformatf("v%0d.s_addr", i), s_addr, v.saddr);
        chk($sformatf("v%0d.s_dat", i), s_dat_o, v.sdo);
        chk($sformatf("v%0d.m0_dat", i), m0_dat, v.r0);
        chk($sformatf("v%0d.m1_dat", i), m1_dat, v.r1);
        chk_bus($sformatf("v%0d", i), v.scs, v.gnt, v.ack0, v.ack1, v.err);
        tick();
    endtask

    // Reference model state: owner -1 means nobody holds the bus.
    int owner, last, waited;

    initial begin
        rst = 1'b1; c0 = 0; we0 = 0; a0 = 0; d0 = 0;
        c1 = 0; we1 = 0; a1 = 0; d1 = 0; sack = 0; sdat = 0;

        //            rst c0 we0 a0        d0        c1 we1 a1        d1        sack sd        scs swe saddr     sdo       gnt    ack0 ack1 r0        r1        err
        vecs[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[1]  = '{0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[2]  = '{0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 2'b01, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[3]  = '{0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 1, 0, 16'h0010, 16'h0000, 2'b01, 1, 0, 16'h1234, 16'h0000, 0};
        vecs[4]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[5]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[6]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 2'b10, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[7]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 1, 16'h00AA, 1, 1, 16'h8000, 16'hBEEF, 2'b10, 0, 1, 16'h0000, 16'h00AA, 0};
        vecs[8]  = '{0, 1, 0, 16'h0020, 16'h1111, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[9]  = '{0, 1, 0, 16'h0020, 16'h1111, 1, 1, 16'h8000, 16'hBEEF, 1, 16'h5555, 1, 0, 16'h0020, 16'h1111, 2'b01, 1, 0, 16'h5555, 16'h0000, 0};
        vecs[10] = '{0, 1, 0, 16'h0020, 16'h1111, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[11] = '{0, 1, 0, 16'h0020, 16'h1111, 1, 1, 16'h8000, 16'hBEEF, 1, 16'h0101, 1, 1, 16'h8000, 16'hBEEF, 2'b10, 0, 1, 16'h0000, 16'h0101, 0};
        vecs[12] = '{0, 1, 0, 16'h0020, 16'h1111, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[13] = '{0, 1, 0, 16'h0020, 16'h1111, 1, 1, 16'h8000, 16'hBEEF, 1, 16'h7777, 1, 0, 16'h0020, 16'h1111, 2'b01, 1, 0, 16'h7777, 16'h0000, 0};
        vecs[14] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[15] = '{0, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[16] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[17] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0};

        tick();
        tick();
        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Watchdog timeout on m0 while m1 waits; the bus passes to m1 afterwards.
        c0 = 1; a0 = 16'h0040; d0 = 16'h0000; we0 = 0;
        #3 chk_bus("to_req", 0, 2'b00, 0, 0, 0);
        tick();
        c1 = 1; a1 = 16'h0050; d1 = 16'h0000; we1 = 0;
        for (int k = 0; k < 8; k++) begin
            #3;
            if (k < 7) begin
                chk_bus($sformatf("to_wait%0d", k), 1, 2'b01, 0, 0, 0);
            end else begin
                chk_bus("to_fire", 0, 2'b01, 1, 0, 1);
                chk("to_fire.m0_dat", m0_dat, 16'hDEAD);
            end
            tick();
        end
        c0 = 0;
        #3 chk_bus("to_bubble", 0, 2'b00, 0, 0, 0);
        tick();

        // m1 gets acked exactly in the watchdog expiry cycle: the real ack wins.
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                sack = 1; sdat = 16'h4242;
            end
            #3;
            if (k == 0) chk("ta_first.s_addr", s_addr, 16'h0050);
            if (k < 7) begin
                chk_bus($sformatf("ta_wait%0d", k), 1, 2'b10, 0, 0, 0);
            end else begin
                chk_bus("ta_ack", 1, 2'b10, 0, 1, 0);
                chk("ta_ack.m1_dat", m1_dat, 16'h4242);
            end
            tick();
        end
        c1 = 0; sack = 0; sdat = 0;
        #3 chk_bus("ta_idle", 0, 2'b00, 0, 0, 0);

        // One m0 transaction so the last-served master is m0 before the reset.
        c0 = 1; a0 = 16'h0070;
        tick();
        sack = 1; sdat = 16'h0001;
        #3 chk_bus("pre_rst", 1, 2'b01, 1, 0, 0);
        tick();
        c0 = 0; sack = 0;
        // Reset while m1 owns the bus: next tie must still go to m0.
        c1 = 1; a1 = 16'h0060;
        tick();
        #3 chk_bus("rst_busy", 1, 2'b10, 0, 0, 0);
        rst = 1; c0 = 1;
        tick();
        rst = 0;
        #3 chk_bus("rst_after", 0, 2'b00, 0, 0, 0);
        tick();
        #3 chk_bus("rst_tie", 1, 2'b01, 0, 0, 0);
        chk("rst_tie.s_addr", s_addr, 16'h0070);

        // Randomised protocol-following traffic against the reference model.
        rst = 1;
        tick();
        rst = 0; c0 = 0; c1 = 0; sack = 0;
        owner = -1; last = 1; waited = 0;
        begin
            logic        p_ack0, p_ack1;
            logic        gcs, fire, acked;
            logic        e_scs, e_swe, e_ack0, e_ack1, e_err;
            logic [1:0]  e_gnt;
            logic [15:0] e_saddr, e_sdo, e_r0, e_r1, rd;
            p_ack0 = 0; p_ack1 = 0;
            for (int n = 0; n < 1500; n++) begin
                if (!c0 || p_ack0 || $urandom_range(0, 59) == 0) begin
                    c0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
                    a0 = 16'($urandom); d0 = 16'($urandom);
                end
                if (!c1 || p_ack1 || $urandom_range(0, 59) == 0) begin
                    c1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
                    a1 = 16'($urandom); d1 = 16'($urandom);
                end
                rst  = ($urandom_range(0, 199) == 0);
                sack = ($urandom_range(0, 3) == 0);
                sdat = 16'($urandom);
                #3;
                e_scs = 0; e_swe = 0; e_ack0 = 0; e_ack1 = 0; e_err = 0;
                e_gnt = 2'b00; e_saddr = 0; e_sdo = 0; e_r0 = 0; e_r1 = 0;
                gcs = 0; fire = 0; acked = 0;
                if (owner >= 0) begin
                    gcs     = (owner == 1) ? c1 : c0;
                    e_gnt   = (owner == 1) ? 2'b10 : 2'b01;
                    e_saddr = (owner == 1) ? a1 : a0;
                    e_sdo   = (owner == 1) ? d1 : d0;
                    if (gcs) begin
                        fire  = (waited == (1 << TW) - 1) && !sack;
                        acked = sack || (waited == (1 << TW) - 1);
                        e_err = fire;
                        e_scs = !fire;
                        e_swe = e_scs && ((owner == 1) ? we1 : we0);
                    end
                    rd = fire ? ERR : sdat;
                    if (owner == 0) begin e_r0 = rd; e_ack0 = acked; end
                    else            begin e_r1 = rd; e_ack1 = acked; end
                end
                chk_bus($sformatf("rnd%0d", n), e_scs, e_gnt, e_ack0, e_ack1, e_err);
                chk($sformatf("rnd%0d.s_we", n), 16'(s_we), 16'(e_swe));
                chk($sformatf("rnd%0d.s_addr", n), s_addr, e_saddr);
                chk($sformatf("rnd%0d.s_dat", n), s_dat_o, e_sdo);
                chk($sformatf("rnd%0d.m0_dat", n), m0_dat, e_r0);
                chk($sformatf("rnd%0d.m1_dat", n), m1_dat, e_r1);
                p_ack0 = m0_ack; p_ack1 = m1_ack;
                @(posedge clk);
                if (rst) begin
                    owner = -1; last = 1; waited = 0;
                end else if (owner < 0) begin
                    if (c0 || c1) begin
                        owner  = (c0 && c1) ? 1 - last : (c0 ? 0 : 1);
                        waited = 0;
                    end
                end else if (!gcs) begin
                    owner = -1;
                end else if (acked) begin
                    last  = owner;
                    owner = -1;
                end else begin
                    waited++;
                end
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, one-slave arbiter for the dcpu memory bus (addr/dat/we/cs/ack protocol).
- Master 0 is the CPU core; master 1 is a DMA/debug loader.
- Sits between the masters and the shared memory/peripheral slave.
- Round-robin grant, held for one full transaction, with an ack-timeout watchdog so a dead slave cannot hang a master.

Parameters:
- TIMEOUT_W, 8: width of the ack watchdog counter. Timeout fires after 2^TIMEOUT_W-1 cycles without ack.
- ERR_DATA, 16'hDEAD: read data returned to a master on timeout.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m0_addr  in  16  master 0 address
- i_m0_dat  in  16  master 0 write data
- i_m0_we  in  1  master 0 write enable
- i_m0_cs  in  1  master 0 request
- o_m0_dat  out  16  read data to master 0
- o_m0_ack  out  1  ack to master 0
- i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs, o_m1_dat, o_m1_ack: same as master 0, for master 1
- o_s_addr  out  16  slave address
- o_s_dat  out  16  slave write data
- o_s_we  out  1  slave write enable
- o_s_cs  out  1  slave select
- i_s_dat  in  16  slave read data
- i_s_ack  in  1  slave ack
- o_err  out  1  one-cycle pulse on timeout
- o_grant  out  2  one-hot current grant (debug); 00 when idle

Behaviour:
- Bus protocol:
  - A master holds cs, addr, dat and we stable until it samples ack high.
  - Ack is a single cycle.
  - cs still high in the cycle after ack is a new request.
- State machine states: IDLE, BUSY.
- IDLE:
  - o_s_cs=0 and both acks are 0.
  - If any cs is high, register the grant and go to BUSY.
  - Only one requester: grant it.
  - Both requesting: grant the master that was not granted last (r_last, reset value 1, so master 0/CPU wins the first tie).
- BUSY:
  - o_s_addr, o_s_dat, o_s_we and o_s_cs are combinationally muxed from the granted master.
  - i_s_ack and i_s_dat are routed to the granted master only; the other master sees ack=0 and dat=0.
  - On i_s_ack=1: update r_last to the granted index, clear the grant, go to IDLE.
  - Re-arbitration therefore costs exactly one bubble cycle per transaction.
- Granted master drops cs while BUSY (protocol violation): abort to IDLE next cycle, no ack, no error.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches 2^TIMEOUT_W-1 with no ack, the arbiter drives ack=1 and dat=ERR_DATA to the granted master that cycle.
  - In the same cycle: o_s_cs is forced 0, o_err pulses 1, r_last updates, state goes to IDLE.
  - i_s_ack arriving in that same cycle takes precedence: normal ack, no error.
- Latency: request in cycle n (IDLE) → slave cs in cycle n+1. Master ack is the same cycle as slave ack (combinational).
- Reset values:
  - State IDLE, grant none, r_last=1, counter 0.
  - o_s_cs=0, o_s_we=0, o_s_addr=0, o_s_dat=0.
  - Acks 0, o_err=0, o_grant=00.
  - Reset mid-transaction drops o_s_cs the cycle after reset asserts. No ack is issued.
- o_s_we is gated with the grant; it is never high while o_s_cs=0.

Test Plan:
- Single master: m0 cs with addr 0x0010 held; slave acks 2 cycles later with 0x1234 → o_s_cs rises 1 cycle after request, o_m0_ack=1 with o_m0_dat=0x1234, o_m1_ack stays 0.
- Simultaneous requests after reset: m0 and m1 both request continuously, slave acks every cycle it is selected → grants alternate 01,10,01,… with one IDLE cycle between them.
- Write pass-through: m1 writes 0xBEEF to 0x8000 → o_s_we=1, o_s_addr=0x8000, o_s_dat=0xBEEF only while BUSY on m1; o_s_we=0 in the IDLE bubble.
- Timeout: TIMEOUT_W=3, slave never acks → after 7 BUSY cycles o_m0_ack=1, o_m0_dat=0xDEAD, o_err pulses once, next grant goes to m1 if pending.
- Ack on timeout cycle: i_s_ack=1 exactly at count 7 → normal data delivered, o_err stays 0.
- Reset mid-transaction: assert i_reset while BUSY on m1 → o_s_cs=0 next cycle, no ack, o_grant=00, next tie grants m0.
